// File: rtl/core_pkg.sv
// Shared types for the execute stage: decoded-op enums, stage bundles.
// Holds rd_ex_t, ex_mem_t, ex_mem_rst, alu_op_t, md_op_t, md_state_t.
package core;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_op_t;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE, MD_BUSY, MD_DONE
  } md_state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LUI, K_AUIPC, K_JAL,
    K_JALR, K_BR, K_MEM, K_MD
  } kind_t;

  typedef struct packed {
    kind_t            kind;
    alu_op_t          alu_op;
    br_op_t           br_op;
    md_op_t           md_op;
    logic             has_imm;
    logic [XLEN-1:0]  imm;
  } de_inst_t;

  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    de_inst_t         de_inst;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic             valid;
  } rd_ex_t;

  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    de_inst_t         de_inst;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  rs2_value;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             valid;
  } ex_mem_t;

  localparam ex_mem_t ex_mem_rst = '0;

  // DIV/DIVU/REM/REMU occupy the upper half of md_op_t
  function automatic logic md_is_div(md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MUL/DIV: 32 radix-2 steps, sign fixup at MD_DONE.
// Ports: clk, rst, start, op, a, b, next_rdy -> busy, done, result.
module ex_muldiv
  import core::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            next_rdy,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  // mul: {acc_hi, multiplier}; div: {remainder, dividend/quotient}
  logic [64:0]     p_q, p_d;
  logic [31:0]     m_q, m_d;
  md_op_t          op_q, op_d;
  logic            neg_q, neg_d;

  logic [31:0] abs_a, abs_b, sa, sb;
  logic        neg_s;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [64:0] mul_nx, div_nx;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  always_comb begin
    sa    = a;
    sb    = b;
    neg_s = 1'b0;
    unique case (op)
      MD_MULH: begin
        sa    = abs_a;
        sb    = abs_b;
        neg_s = a[31] ^ b[31];
      end
      MD_MULHSU: begin
        sa    = abs_a;
        neg_s = a[31];
      end
      MD_DIV: begin
        sa    = abs_a;
        sb    = abs_b;
        // x/0 must stay all-ones
        neg_s = (a[31] ^ b[31]) && (b != '0);
      end
      MD_REM: begin
        sa    = abs_a;
        sb    = abs_b;
        neg_s = a[31];
      end
      default: ;
    endcase
  end

  assign sum    = p_q[64:32]
                + (p_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_nx = {1'b0, sum, p_q[31:1]};

  assign rem_sh = {p_q[63:32], p_q[31]};
  assign diff   = {1'b0, rem_sh} - {2'b0, m_q};
  assign div_nx = diff[33]
                ? {rem_sh, p_q[30:0], 1'b0}
                : {diff[32:0], p_q[30:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    op_d    = op_q;
    neg_d   = neg_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = 5'd31;
          op_d    = op;
          neg_d   = neg_s;
          if (md_is_div(op)) begin
            m_d = sb;
            p_d = {33'd0, sa};
          end else begin
            m_d = sa;
            p_d = {33'd0, sb};
          end
        end
      end
      MD_BUSY: begin
        p_d = md_is_div(op_q) ? div_nx : mul_nx;
        if (cnt_q == 5'd0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MD_DONE: begin
        if (next_rdy) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  assign prod_s = neg_q ? (~p_q[63:0] + 64'd1) : p_q[63:0];
  assign quo_s  = neg_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
  assign rem_s  = neg_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];

  always_comb begin
    result = '0;
    unique case (op_q)
      MD_MUL:                       result = p_q[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[63:32];
      MD_DIV, MD_DIVU:              result = quo_s;
      MD_REM, MD_REMU:              result = rem_s;
      default:                      result = '0;
    endcase
  end

  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch compare, output register, optional MUL/DIV.
// Ports: clk, rst, en, next_rdy, rd_ex -> ex_mem, rdy. Macro CORE_MULDIV_EN.
module ex_stage
  import core::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    next_rdy,
  input  rd_ex_t  rd_ex,
  output ex_mem_t ex_mem,
  output logic    rdy
);

  ex_mem_t         ex_mem_q, ex_mem_d, sc;
  logic [XLEN-1:0] op_a, op_b, rs2, alu_res;
  logic [XLEN-1:0] pc_imm, pc4, rs1_imm;
  logic [4:0]      shamt;
  logic            take;
  md_state_t       md_state;
  logic            md_start;
  logic [XLEN-1:0] md_result;

  assign op_a    = rd_ex.rs1_value;
  assign rs2     = rd_ex.rs2_value;
  assign op_b    = rd_ex.de_inst.has_imm ? rd_ex.de_inst.imm : rs2;
  assign shamt   = op_b[4:0];
  assign pc_imm  = rd_ex.pc + rd_ex.de_inst.imm;
  assign pc4     = rd_ex.pc + 32'd4;
  assign rs1_imm = op_a + rd_ex.de_inst.imm;

  always_comb begin
    alu_res = '0;
    unique case (rd_ex.de_inst.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    unique case (rd_ex.de_inst.br_op)
      BR_EQ:   take = (op_a == rs2);
      BR_NE:   take = (op_a != rs2);
      BR_LT:   take = $signed(op_a) < $signed(rs2);
      BR_GE:   take = $signed(op_a) >= $signed(rs2);
      BR_LTU:  take = op_a < rs2;
      BR_GEU:  take = op_a >= rs2;
      default: take = 1'b0;
    endcase
  end

  // single-cycle view of the current rd_ex
  always_comb begin
    sc           = ex_mem_rst;
    sc.inst      = rd_ex.inst;
    sc.pc        = rd_ex.pc;
    sc.de_inst   = rd_ex.de_inst;
    sc.rs2_value = rs2;
    sc.valid     = en && rd_ex.valid;
    unique case (rd_ex.de_inst.kind)
      K_ALU:   sc.result = alu_res;
      K_LUI:   sc.result = rd_ex.de_inst.imm;
      K_AUIPC: sc.result = pc_imm;
      K_JAL: begin
        sc.result    = pc4;
        sc.br_taken  = 1'b1;
        sc.br_target = pc_imm;
      end
      K_JALR: begin
        sc.result    = pc4;
        sc.br_taken  = 1'b1;
        sc.br_target = {rs1_imm[XLEN-1:1], 1'b0};
      end
      K_BR: begin
        sc.br_taken  = take;
        sc.br_target = pc_imm;
      end
      K_MEM:   sc.result = rs1_imm;
      K_MD:    sc.result = '0;
      default: ;
    endcase
  end

`ifdef CORE_MULDIV_EN
  logic md_busy, md_done;

  assign md_start = rd_ex.valid && en
                 && (rd_ex.de_inst.kind == K_MD)
                 && (md_state == MD_IDLE);

  ex_muldiv u_md (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .op       (rd_ex.de_inst.md_op),
    .a        (op_a),
    .b        (rs2),
    .next_rdy (next_rdy),
    .busy     (md_busy),
    .done     (md_done),
    .result   (md_result)
  );

  always_comb begin
    md_state = MD_IDLE;
    if (md_done)      md_state = MD_DONE;
    else if (md_busy) md_state = MD_BUSY;
  end
`else
  assign md_start  = 1'b0;
  assign md_state  = MD_IDLE;
  assign md_result = '0;
`endif

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (next_rdy) begin
      ex_mem_d = sc;
      if (md_state == MD_DONE) begin
        // rd_ex is still the held MUL/DIV instruction
        ex_mem_d.result = md_result;
        ex_mem_d.valid  = 1'b1;
      end else if (md_state != MD_IDLE || md_start) begin
        ex_mem_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_mem_q <= ex_mem_rst;
    else     ex_mem_q <= ex_mem_d;
  end

  assign ex_mem = ex_mem_q;
  assign rdy    = !rst && en && next_rdy
               && (md_state == MD_IDLE) && !md_start;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random traffic
// compared each cycle against a behavioural model of the stage.
module tb_ex_stage;
  import core::*;

`ifdef CORE_MULDIV_EN
  localparam bit MDEN = 1'b1;
`else
  localparam bit MDEN = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    rst, en, next_rdy, rdy;
  rd_ex_t  rd_ex;
  ex_mem_t ex_mem;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .next_rdy (next_rdy),
    .rd_ex    (rd_ex),
    .ex_mem   (ex_mem),
    .rdy      (rdy)
  );

  int checks = 0;
  int failures = 0;

  ex_mem_t     m_exp;
  bit          m_full = 1'b0;
  bit          m_act = 1'b0;
  int          m_steps = 0;
  logic [31:0] m_res = '0;
  bit          m_cmpl = 1'b0;
  bit          m_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] md_ref(md_op_t op, logic [31:0] a,
                                         logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0;
    case (op)
      MD_MUL:    begin p = ua * ub; r = p[31:0];  end
      MD_MULH:   begin p = sa * sb; r = p[63:32]; end
      MD_MULHSU: begin p = sa * ub; r = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MD_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      MD_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      MD_REMU: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic ex_mem_t single_ref(rd_ex_t r, logic en_i);
    ex_mem_t e;
    de_inst_t d;
    logic [31:0] a, b, s;
    int unsigned sh;
    logic signed [63:0] ax;
    e = '0;
    d = r.de_inst;
    a = r.rs1_value;
    s = r.rs2_value;
    b = d.has_imm ? d.imm : s;
    sh = b[4:0];
    e.inst = r.inst;
    e.pc = r.pc;
    e.de_inst = d;
    e.rs2_value = s;
    e.valid = en_i && r.valid;
    case (d.kind)
      K_ALU: begin
        case (d.alu_op)
          ALU_ADD:  e.result = a + b;
          ALU_SUB:  e.result = a - b;
          ALU_SLL:  e.result = a << sh;
          ALU_SLT:  e.result = ($signed(a) < $signed(b)) ? 1 : 0;
          ALU_SLTU: e.result = (a < b) ? 1 : 0;
          ALU_XOR:  e.result = a ^ b;
          ALU_SRL:  e.result = a >> sh;
          ALU_SRA: begin
            ax = {{32{a[31]}}, a};
            ax = ax >>> sh;
            e.result = ax[31:0];
          end
          ALU_OR:   e.result = a | b;
          ALU_AND:  e.result = a & b;
          default:  e.result = '0;
        endcase
      end
      K_LUI:   e.result = d.imm;
      K_AUIPC: e.result = r.pc + d.imm;
      K_JAL: begin
        e.result = r.pc + 4;
        e.br_taken = 1'b1;
        e.br_target = r.pc + d.imm;
      end
      K_JALR: begin
        e.result = r.pc + 4;
        e.br_taken = 1'b1;
        e.br_target = (a + d.imm) & 32'hFFFF_FFFE;
      end
      K_BR: begin
        e.br_target = r.pc + d.imm;
        case (d.br_op)
          BR_EQ:  e.br_taken = (a == s);
          BR_NE:  e.br_taken = (a != s);
          BR_LT:  e.br_taken = ($signed(a) < $signed(s));
          BR_GE:  e.br_taken = ($signed(a) >= $signed(s));
          BR_LTU: e.br_taken = (a < s);
          BR_GEU: e.br_taken = (a >= s);
          default: e.br_taken = 1'b0;
        endcase
      end
      K_MEM:   e.result = a + d.imm;
      default: e.result = '0;
    endcase
    return e;
  endfunction

  function automatic rd_ex_t mk(kind_t k, alu_op_t ao, br_op_t bo,
                                md_op_t mo, logic hi, logic [31:0] imm,
                                logic [31:0] pc, logic [31:0] a,
                                logic [31:0] b);
    rd_ex_t r;
    r.inst = $urandom;
    r.pc = pc;
    r.de_inst.kind = k;
    r.de_inst.alu_op = ao;
    r.de_inst.br_op = bo;
    r.de_inst.md_op = mo;
    r.de_inst.has_imm = hi;
    r.de_inst.imm = imm;
    r.rs1_value = a;
    r.rs2_value = b;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  function automatic rd_ex_t rinst();
    rd_ex_t r;
    logic [31:0] imm;
    imm = $urandom;
    if ($urandom_range(0, 1) == 1) imm = {{20{imm[11]}}, imm[11:0]};
    r = mk(kind_t'($urandom_range(0, 7)),
           alu_op_t'($urandom_range(0, 9)),
           br_op_t'($urandom_range(0, 5)),
           md_op_t'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), imm, $urandom, rval(), rval());
    r.valid = ($urandom_range(0, 7) != 0);
    return r;
  endfunction

  task automatic bubble();
    m_exp.valid = 1'b0;
    m_full = 1'b0;
  endtask

  // one clock: check rdy mid-cycle, advance model, check ex_mem
  task automatic tick();
    @(negedge clk);
    m_rdy = !rst && en && next_rdy && !m_act
         && !(MDEN && rd_ex.valid && en && rd_ex.de_inst.kind == K_MD);
    chk("rdy", {31'd0, rdy}, {31'd0, m_rdy});
    @(posedge clk);
    m_cmpl = 1'b0;
    if (rst) begin
      m_exp = ex_mem_rst;
      m_full = 1'b1;
      m_act = 1'b0;
      m_steps = 0;
    end else if (m_act && m_steps == 32) begin
      if (next_rdy) begin
        m_exp = single_ref(rd_ex, en);
        m_exp.result = m_res;
        m_exp.valid = 1'b1;
        m_full = 1'b1;
        m_act = 1'b0;
        m_cmpl = 1'b1;
      end
    end else if (m_act) begin
      m_steps++;
      if (next_rdy) bubble();
    end else if (MDEN && rd_ex.valid && en
                 && rd_ex.de_inst.kind == K_MD) begin
      m_act = 1'b1;
      m_steps = 0;
      m_res = md_ref(rd_ex.de_inst.md_op, rd_ex.rs1_value,
                     rd_ex.rs2_value);
      if (next_rdy) bubble();
    end else if (next_rdy) begin
      m_exp = single_ref(rd_ex, en);
      m_full = m_exp.valid;
    end
    #1;
    checks++;
    if (m_full ? (ex_mem !== m_exp) : (ex_mem.valid !== m_exp.valid)) begin
      failures++;
      $display("FAIL ex_mem: got %h want %h", ex_mem, m_exp);
    end
  endtask

`ifdef CORE_MULDIV_EN
  task automatic run_md(input rd_ex_t r, output logic [31:0] res,
                        output int bubbles);
    bit fin;
    fin = 1'b0;
    bubbles = 0;
    rd_ex = r;
    en = 1'b1;
    next_rdy = 1'b1;
    for (int i = 0; i < 100 && !fin; i++) begin
      tick();
      if (ex_mem.valid === 1'b1) fin = 1'b1;
      else bubbles++;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL md_timeout: got no result want valid in 100");
    end
    res = ex_mem.result;
  endtask
`endif

  initial begin
    logic [31:0] res;
    int nb;
    rst = 1'b1;
    en = 1'b0;
    next_rdy = 1'b0;
    rd_ex = '0;
    m_exp = ex_mem_rst;
    tick();
    tick();
    chk("rst_valid", {31'd0, ex_mem.valid}, 32'd0);
    chk("rst_result", ex_mem.result, 32'd0);

    rst = 1'b0;
    en = 1'b1;
    next_rdy = 1'b1;
    rd_ex = mk(K_ALU, ALU_ADD, BR_EQ, MD_MUL, 1'b0, 0, 32'h40,
               32'hFFFF_FFFF, 32'd1);
    tick();
    chk("add_wrap", ex_mem.result, 32'd0);
    chk("add_valid", {31'd0, ex_mem.valid}, 32'd1);

    rd_ex = mk(K_BR, ALU_ADD, BR_LT, MD_MUL, 1'b1, 32'hFFFF_FFF8,
               32'h100, 32'hFFFF_FFFF, 32'd0);
    tick();
    chk("blt_taken", {31'd0, ex_mem.br_taken}, 32'd1);
    chk("blt_target", ex_mem.br_target, 32'hF8);
    rd_ex.rs1_value = 32'd1;
    tick();
    chk("blt_not", {31'd0, ex_mem.br_taken}, 32'd0);

`ifdef CORE_MULDIV_EN
    run_md(mk(K_MD, ALU_ADD, BR_EQ, MD_DIV, 1'b0, 0, 0, 7, 0), res, nb);
    chk("div0_q", res, 32'hFFFF_FFFF);
    chk("div0_bubbles", nb, 33);
    run_md(mk(K_MD, ALU_ADD, BR_EQ, MD_REM, 1'b0, 0, 0, 7, 0), res, nb);
    chk("rem0_r", res, 32'd7);
    run_md(mk(K_MD, ALU_ADD, BR_EQ, MD_DIV, 1'b0, 0, 0,
              32'h8000_0000, 32'hFFFF_FFFF), res, nb);
    chk("div_ovf", res, 32'h8000_0000);
    run_md(mk(K_MD, ALU_ADD, BR_EQ, MD_MULH, 1'b0, 0, 0,
              32'h8000_0000, 32'h8000_0000), res, nb);
    chk("mulh_min", res, 32'h4000_0000);

    begin
      ex_mem_t prev;
      int writes;
      writes = 0;
      prev = ex_mem;
      rd_ex = mk(K_MD, ALU_ADD, BR_EQ, MD_MUL, 1'b0, 0, 0, 6, 7);
      next_rdy = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        if (c == 40) next_rdy = 1'b1;
        tick();
        if (ex_mem !== prev) writes++;
        prev = ex_mem;
      end
      chk("mul_hold_writes", writes, 1);
      chk("mul_hold_res", ex_mem.result, 32'd42);
      chk("mul_hold_valid", {31'd0, ex_mem.valid}, 32'd1);
    end

    rd_ex = mk(K_MD, ALU_ADD, BR_EQ, MD_DIV, 1'b0, 0, 0, 100, 7);
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, ex_mem.valid}, 32'd0);
    rd_ex = mk(K_ALU, ALU_ADD, BR_EQ, MD_MUL, 1'b0, 0, 0, 2, 3);
    #1;
    chk("rst_mid_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("rst_mid_add", ex_mem.result, 32'd5);
    chk("rst_mid_addv", {31'd0, ex_mem.valid}, 32'd1);
`else
    rd_ex = mk(K_MD, ALU_ADD, BR_EQ, MD_DIV, 1'b0, 0, 0, 7, 0);
    #1;
    chk("md_off_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("md_off_res", ex_mem.result, 32'd0);
    chk("md_off_valid", {31'd0, ex_mem.valid}, 32'd1);
`endif

    rd_ex = rinst();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (m_rdy || m_cmpl || rst) rd_ex = rinst();
      rst = ($urandom_range(0, 99) == 0);
      en = m_act ? 1'b1 : ($urandom_range(0, 9) != 0);
      next_rdy = ($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
